// File: rtl/fifo_pkg.sv
// Types shared by the vector FIFO and its consumer-side sequencer.
package fifo_pkg;
  typedef enum logic [2:0] {
    IDLE,
    WAIT_RDY,
    POP,
    DRAIN,
    DONE
  } rd_state_e;
endpackage

// File: rtl/global_pkg.sv
// Shared scalar types for the vector datapath.
package global_pkg;
  localparam int unsigned DATA_WIDTH   = 8;
  localparam int unsigned NIBBLE_WIDTH = 4;

  typedef logic [DATA_WIDTH-1:0]   data_t;
  typedef logic [NIBBLE_WIDTH-1:0] nibble_t;
endpackage

// File: rtl/vector_rd_fsm.sv
// Sequencer FSM: pops n_q elements per row for rows_q rows, with abort and ready stall.
module vector_rd_fsm
  import fifo_pkg::*;
#(
  parameter int unsigned N_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  input  logic [N_W-1:0] n,
  input  logic [N_W-1:0] rows,
  input  logic           fifo_ready,
  output logic           pop,
  output logic           busy,
  output logic           done,
  output logic [N_W-1:0] pop_idx,
  output logic           pop_last_c
);

  rd_state_e      state, state_d;
  logic [N_W-1:0] pop_idx_d;
  logic [N_W-1:0] row_cnt, row_cnt_d;
  logic [N_W-1:0] n_q, n_d;
  logic [N_W-1:0] rows_q, rows_d;

  assign pop_last_c = (state == POP) && (pop_idx == n_q - N_W'(1));

  // Next-state and counter update; abort overrides every transition.
  always_comb begin
    state_d   = state;
    pop_idx_d = pop_idx;
    row_cnt_d = row_cnt;
    n_d       = n_q;
    rows_d    = rows_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            n_d       = n;
            rows_d    = rows;
            pop_idx_d = '0;
            row_cnt_d = '0;
            if (n == '0 || rows == '0) state_d = DONE;
            else if (fifo_ready)       state_d = POP;
            else                       state_d = WAIT_RDY;
          end
        end
        WAIT_RDY: begin
          if (fifo_ready) state_d = POP;
        end
        POP: begin
          if (pop_idx == n_q - N_W'(1)) begin
            pop_idx_d = '0;
            state_d   = DRAIN;
          end else begin
            pop_idx_d = pop_idx + N_W'(1);
          end
        end
        DRAIN: begin
          row_cnt_d = row_cnt + N_W'(1);
          if (row_cnt == rows_q - N_W'(1)) state_d = DONE;
          else                             state_d = POP;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pop_idx <= '0;
      row_cnt <= '0;
      n_q     <= '0;
      rows_q  <= '0;
      pop     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_d;
      pop_idx <= pop_idx_d;
      row_cnt <= row_cnt_d;
      n_q     <= n_d;
      rows_q  <= rows_d;
      pop     <= (state_d == POP);
      busy    <= (state_d != IDLE);
      done    <= (state_d == DONE);
    end
  end

endmodule

// File: rtl/vector_reader.sv
// Consumer-side sequencer for fifo_vector: replays the stored vector once per row and
// pushes every popped element straight back so the vector survives.
module vector_reader #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [N_W-1:0]    N,
  input  logic [N_W-1:0]    rows,
  input  logic              fifo_ready,
  input  logic [DATA_W-1:0] fifo_data_out,
  output logic              fifo_pop,
  output logic              fifo_push,
  output logic [DATA_W-1:0] fifo_data_in,
  output logic              elem_valid,
  output logic [DATA_W-1:0] elem_data,
  output logic [N_W-1:0]    elem_idx,
  output logic              elem_last,
  output logic              row_done,
  output logic              busy,
  output logic              done
);

  logic           pop_last_c;
  logic [N_W-1:0] pop_idx;
  logic           pop_d;
  logic [N_W-1:0] idx_d;
  logic           last_d;

  vector_rd_fsm #(.N_W(N_W)) u_fsm (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .n          (N),
    .rows       (rows),
    .fifo_ready (fifo_ready),
    .pop        (fifo_pop),
    .busy       (busy),
    .done       (done),
    .pop_idx    (pop_idx),
    .pop_last_c (pop_last_c)
  );

  // Align index and last flag with the FIFO's one-cycle read latency.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      pop_d  <= 1'b0;
      idx_d  <= '0;
      last_d <= 1'b0;
    end else begin
      pop_d  <= fifo_pop;
      idx_d  <= fifo_pop ? pop_idx : '0;
      last_d <= pop_last_c;
    end
  end

  assign elem_valid   = pop_d;
  assign fifo_push    = pop_d;
  assign elem_data    = pop_d ? fifo_data_out : '0;
  assign fifo_data_in = elem_data;
  assign elem_idx     = idx_d;
  assign elem_last    = last_d;
  assign row_done     = last_d;

endmodule

// File: tb/tb_vector_reader.sv
// Self-checking bench for vector_reader with a queue-based fifo_vector model.
module tb_vector_reader;
  localparam int unsigned DW = 8;
  localparam int unsigned NW = 4;

  logic          clk = 1'b0;
  logic          rst, start, abort, fifo_ready;
  logic [NW-1:0] n_in, rows_in;
  logic [DW-1:0] fifo_data_out = '0;
  logic          fifo_pop, fifo_push, elem_valid, elem_last, row_done, busy, done;
  logic [DW-1:0] fifo_data_in, elem_data;
  logic [NW-1:0] elem_idx;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] vec[8];

  typedef struct {
    bit pop, push, valid, last, rdone, busy, done;
    int data;
    int idx;
  } exp_t;

  typedef struct {
    int n;
    int rows;
    int stall;
    int extra;
    int exp_done;
    int exp_pops;
  } vec_t;

  always #5 clk = ~clk;

  vector_reader #(.DATA_W(DW), .N_W(NW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .N(n_in), .rows(rows_in),
    .fifo_ready(fifo_ready), .fifo_data_out(fifo_data_out),
    .fifo_pop(fifo_pop), .fifo_push(fifo_push), .fifo_data_in(fifo_data_in),
    .elem_valid(elem_valid), .elem_data(elem_data), .elem_idx(elem_idx),
    .elem_last(elem_last), .row_done(row_done), .busy(busy), .done(done)
  );

  // fifo_vector model: registered read data, write appended at the tail.
  always @(posedge clk) begin
    if (fifo_pop) begin
      if (q.size() > 0) fifo_data_out <= q.pop_front();
      else              fifo_data_out <= '0;
    end
    if (fifo_push) q.push_back(fifo_data_in);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected outputs in cycle t after start, derived from the row-period timing rules.
  function automatic exp_t model(input int n, input int r, input int s, input int t);
    exp_t e;
    int total, u, k;
    e = '{default: 0};
    if (n == 0 || r == 0) begin
      e.busy = (t == 1);
      e.done = (t == 1);
      return e;
    end
    total = r * (n + 1);
    if (t <= s) begin
      e.busy = (t >= 1);
      return e;
    end
    u = t - s;
    e.busy = (u <= total + 1);
    e.done = (u == total + 1);
    e.pop  = (u <= total) && (((u - 1) % (n + 1)) < n);
    if (u >= 2 && u <= total + 1 && ((u - 2) % (n + 1)) < n) begin
      k       = (u - 2) % (n + 1);
      e.valid = 1'b1;
      e.push  = 1'b1;
      e.idx   = k;
      e.data  = int'(vec[k]);
      e.last  = (k == n - 1);
      e.rdone = e.last;
    end
    return e;
  endfunction

  task automatic check_cycle(input string tag, input int t, input exp_t e);
    logic [6:0] act_ctl, exp_ctl;
    act_ctl = {fifo_pop, fifo_push, elem_valid, elem_last, row_done, busy, done};
    exp_ctl = {e.pop, e.push, e.valid, e.last, e.rdone, e.busy, e.done};
    chk($sformatf("%s c%0d ctl{pop,push,valid,last,rdone,busy,done}", tag, t),
        int'(act_ctl), int'(exp_ctl));
    chk($sformatf("%s c%0d elem_data", tag, t), int'(elem_data), e.data);
    chk($sformatf("%s c%0d elem_idx", tag, t), int'(elem_idx), e.idx);
    chk($sformatf("%s c%0d fifo_data_in", tag, t), int'(fifo_data_in), e.data);
  endtask

  task automatic load(input int n);
    q.delete();
    for (int i = 0; i < n; i++) q.push_back(vec[i]);
  endtask

  // One full sequence; N/rows/ready are scrambled once the sequence is under way.
  task automatic run_seq(input string tag, input int n, input int r, input int s,
                         input int extra, output int done_cyc, output int pops);
    int last_t;
    exp_t e;
    load(n);
    done_cyc   = -1;
    pops       = 0;
    last_t     = (n == 0 || r == 0) ? 3 : s + r * (n + 1) + 3;
    start      = 1'b1;
    n_in       = NW'(n);
    rows_in    = NW'(r);
    fifo_ready = (s == 0);
    for (int t = 1; t <= last_t; t++) begin
      @(posedge clk); #1;
      start      = (t == extra);
      n_in       = NW'($urandom);
      rows_in    = NW'($urandom);
      fifo_ready = (t < s) ? 1'b0 : (t == s) ? 1'b1 : 1'($urandom_range(0, 1));
      e = model(n, r, s, t);
      check_cycle(tag, t, e);
      if (fifo_pop) pops++;
      if (done && done_cyc < 0) done_cyc = t;
    end
    chk($sformatf("%s fifo size after", tag), q.size(), n);
    for (int i = 0; i < n && i < q.size(); i++)
      chk($sformatf("%s fifo[%0d] after", tag, i), int'(q[i]), int'(vec[i]));
  endtask

  // mode 0: abort in cycle 3; mode 1: start with abort; mode 2: rst in cycle 3.
  task automatic abort_run(input string tag, input int mode);
    exp_t z;
    z = '{default: 0};
    load(5);
    start      = 1'b1;
    n_in       = NW'(5);
    rows_in    = NW'(2);
    fifo_ready = 1'b1;
    abort      = (mode == 1);
    for (int t = 1; t <= 6; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
      abort = (mode == 0 && t == 3);
      rst   = (mode == 2 && t == 3);
      if (mode == 1 || t >= 4) check_cycle(tag, t, z);
      else                     check_cycle(tag, t, model(5, 2, 0, t));
    end
  endtask

  vec_t tbl[6];
  int   dcyc, npops;

  initial begin
    tbl[0] = '{n: 5, rows: 1, stall: 0, extra: 3, exp_done: 7,  exp_pops: 5};
    tbl[1] = '{n: 5, rows: 3, stall: 0, extra: 0, exp_done: 19, exp_pops: 15};
    tbl[2] = '{n: 5, rows: 1, stall: 4, extra: 0, exp_done: 11, exp_pops: 5};
    tbl[3] = '{n: 0, rows: 2, stall: 0, extra: 0, exp_done: 1,  exp_pops: 0};
    tbl[4] = '{n: 1, rows: 2, stall: 0, extra: 0, exp_done: 5,  exp_pops: 2};
    tbl[5] = '{n: 2, rows: 2, stall: 1, extra: 2, exp_done: 8,  exp_pops: 4};
    vec[0] = 8'd3; vec[1] = 8'd1; vec[2] = 8'd4; vec[3] = 8'd1;
    vec[4] = 8'd5; vec[5] = 8'd9; vec[6] = 8'd2; vec[7] = 8'd6;

    rst = 1'b1; start = 1'b0; abort = 1'b0; fifo_ready = 1'b0;
    n_in = '0; rows_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check_cycle("reset", 0, '{default: 0});
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      run_seq($sformatf("tbl%0d", i), tbl[i].n, tbl[i].rows, tbl[i].stall, tbl[i].extra,
              dcyc, npops);
      chk($sformatf("tbl%0d done cycle", i), dcyc, tbl[i].exp_done);
      chk($sformatf("tbl%0d pop count", i), npops, tbl[i].exp_pops);
    end

    abort_run("abort_c3", 0);
    abort_run("start_abort", 1);
    abort_run("rst_mid", 2);

    vec[0] = 8'd7; vec[1] = 8'd2;
    run_seq("reload72", 2, 2, 0, 0, dcyc, npops);
    chk("reload72 done cycle", dcyc, 7);
    chk("reload72 pop count", npops, 4);

    for (int it = 0; it < 25; it++) begin
      int n, r, s, x;
      for (int i = 0; i < 8; i++) vec[i] = DW'($urandom);
      n = int'($urandom_range(0, 7));
      r = int'($urandom_range(0, 3));
      s = int'($urandom_range(0, 3));
      x = (n > 0 && r > 0 && $urandom_range(0, 1) == 1) ? s + 2 : 0;
      if (n == 0 || r == 0) s = 0;
      run_seq($sformatf("rnd%0d", it), n, r, s, x, dcyc, npops);
      chk($sformatf("rnd%0d pop count", it), npops, n * r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
